// File: rtl/instr_word_packer.sv
// Packs decoded miniMIPS fields into 16-bit instruction words and streams
// address/word pairs to instruction memory through a 2-entry buffer.
module instr_word_packer #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              finish,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              r_type,
   input  logic [3:0]        opcode,
   input  logic [2:0]        rs,
   input  logic [2:0]        rt,
   input  logic [2:0]        rd,
   input  logic [2:0]        funct,
   input  logic [5:0]        immed,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [15:0]       out_data,
   output logic [ADDR_W:0]   words,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

   localparam logic [ADDR_W:0] DepthCount = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] OneCount   = (ADDR_W+1)'(1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W:0]   words_q, words_d;
   logic [1:0]        count_q, count_d;
   logic [ADDR_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
   logic [15:0]       data0_q, data0_d, data1_q, data1_d;
   logic              inReady_q, inReady_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              accept;
   logic              pop;
   logic [15:0]       packedWord;
   logic [ADDR_W-1:0] pushAddr;
   logic [ADDR_W:0]   wordsInc;

   // Slot 0 is always the buffer head; slot 1 only fills when the head is stalled.
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      words_d   = words_q;
      count_d   = count_q;
      addr0_d   = addr0_q;
      addr1_d   = addr1_q;
      data0_d   = data0_q;
      data1_d   = data1_q;

      packedWord = r_type ? {opcode, rs, rt, rd, funct} : {opcode, rs, rt, immed};
      pushAddr   = base_q + words_q[ADDR_W-1:0];
      wordsInc   = words_q + OneCount;
      accept     = in_valid && inReady_q;
      pop        = (count_q != 2'd0) && out_ready;

      unique case ({accept, pop})
         2'b10: begin
            if (count_q == 2'd0) begin
               addr0_d = pushAddr;
               data0_d = packedWord;
            end else begin
               addr1_d = pushAddr;
               data1_d = packedWord;
            end
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            addr0_d = addr1_q;
            data0_d = data1_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            // Accept needs a free slot and pop needs a full one, so occupancy is 1 here.
            addr0_d = pushAddr;
            data0_d = packedWord;
         end
         default: ;
      endcase

      if (accept) begin
         words_d = wordsInc;
      end

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               base_d  = base_addr;
               words_d = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (finish || (accept && (wordsInc == DepthCount))) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (count_d == 2'd0) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Handshake and status flags are registered from next-state so out_ready never reaches in_ready.
      inReady_d = (state_d == LOAD) && (count_d != 2'd2);
      busy_d    = (state_d == LOAD) || (state_d == DRAIN);
      done_d    = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         base_q    <= '0;
         words_q   <= '0;
         count_q   <= 2'd0;
         addr0_q   <= '0;
         addr1_q   <= '0;
         data0_q   <= '0;
         data1_q   <= '0;
         inReady_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         words_q   <= words_d;
         count_q   <= count_d;
         addr0_q   <= addr0_d;
         addr1_q   <= addr1_d;
         data0_q   <= data0_d;
         data1_q   <= data1_d;
         inReady_q <= inReady_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign in_ready  = inReady_q;
   assign out_valid = (count_q != 2'd0);
   assign out_addr  = addr0_q;
   assign out_data  = data0_q;
   assign words     = words_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_instr_word_packer.sv
// Bench for instr_word_packer: table-driven field vectors plus a scoreboard
// that checks every popped address/word pair in order.
module tb_instr_word_packer;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 4;

   logic              clk;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic              finish;
   logic              in_valid;
   logic              in_ready;
   logic              r_type;
   logic [3:0]        opcode;
   logic [2:0]        rs, rt, rd, funct;
   logic [5:0]        immed;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_addr;
   logic [15:0]       out_data;
   logic [ADDR_W:0]   words;
   logic              busy;
   logic              done;

   typedef struct {
      logic        rType;
      logic [3:0]  opcode;
      logic [2:0]  rs;
      logic [2:0]  rt;
      logic [2:0]  rd;
      logic [2:0]  funct;
      logic [5:0]  immed;
      logic [15:0] expData;
   } vec_t;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [15:0]       data;
   } exp_t;

   vec_t vecs [8];
   exp_t expQ [$];

   int                totalChecks = 0;
   int                passChecks  = 0;
   int                acceptCount = 0;
   int                sessIdx     = 0;
   logic [ADDR_W-1:0] sessBase    = '0;
   logic [15:0]       curData     = '0;

   instr_word_packer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .finish    (finish),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .r_type    (r_type),
      .opcode    (opcode),
      .rs        (rs),
      .rt        (rt),
      .rd        (rd),
      .funct     (funct),
      .immed     (immed),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_addr  (out_addr),
      .out_data  (out_data),
      .words     (words),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      totalChecks++;
      if (actual === expected) begin
         passChecks++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Handshakes are sampled mid-cycle; inputs change 2 time units after the rising edge.
   always @(negedge clk) begin
      if (!reset) begin
         if (in_valid && in_ready) begin
            expQ.push_back('{addr: sessBase + ADDR_W'(sessIdx), data: curData});
            sessIdx++;
            acceptCount++;
         end
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               totalChecks++;
               $display("[TB] FAIL unexpected pop: got addr 0x%0h data 0x%0h, expected no word", out_addr, out_data);
            end else begin
               exp_t e;
               e = expQ.pop_front();
               checkOutput("pop addr", 32'(out_addr), 32'(e.addr));
               checkOutput("pop data", 32'(out_data), 32'(e.data));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input int idx);
      r_type  = vecs[idx].rType;
      opcode  = vecs[idx].opcode;
      rs      = vecs[idx].rs;
      rt      = vecs[idx].rt;
      rd      = vecs[idx].rd;
      funct   = vecs[idx].funct;
      immed   = vecs[idx].immed;
      curData = vecs[idx].expData;
   endtask

   task automatic sendWord(input int idx);
      int guard;
      guard = 0;
      applyStimulus(idx);
      in_valid = 1'b1;
      while (!in_ready && guard < 20) begin
         tick();
         guard++;
      end
      if (!in_ready) begin
         totalChecks++;
         $display("[TB] FAIL accept timeout: in_ready 0 after %0d cycles, expected 1", guard);
      end else begin
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic startSession(input logic [ADDR_W-1:0] base);
      base_addr = base;
      sessBase  = base;
      sessIdx   = 0;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      checkOutput("start busy", 32'(busy), 32'd1);
      checkOutput("start done", 32'(done), 32'd0);
      checkOutput("start words", 32'(words), 32'd0);
   endtask

   // Streams four vectors with out_ready high; the fourth reaches DEPTH and ends the session.
   task automatic runSession(input logic [ADDR_W-1:0] base, input int first);
      logic [ADDR_W-1:0] ea;
      startSession(base);
      checkOutput("first LOAD in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < DEPTH; i++) begin
         sendWord(first + i);
         ea = base + ADDR_W'(i);
         checkOutput("head valid", 32'(out_valid), 32'd1);
         checkOutput("head addr", 32'(out_addr), 32'(ea));
         checkOutput("head data", 32'(out_data), 32'(vecs[first + i].expData));
         checkOutput("word count", 32'(words), 32'(i + 1));
      end
      checkOutput("drain busy", 32'(busy), 32'd1);
      checkOutput("drain done", 32'(done), 32'd0);
      checkOutput("drain in_ready", 32'(in_ready), 32'd0);
      tick();
      checkOutput("end done", 32'(done), 32'd1);
      checkOutput("end busy", 32'(busy), 32'd0);
      checkOutput("end words", 32'(words), 32'(DEPTH));
      checkOutput("end out_valid", 32'(out_valid), 32'd0);
   endtask

   initial begin
      int acceptsBefore;

      vecs[0] = '{1'b1, 4'h0, 3'd1, 3'd2, 3'd3, 3'd5, 6'h00, 16'h029D};
      vecs[1] = '{1'b0, 4'h4, 3'd7, 3'd0, 3'd5, 3'd6, 6'h3F, 16'h4E3F};
      vecs[2] = '{1'b1, 4'hF, 3'd7, 3'd7, 3'd7, 3'd7, 6'h2A, 16'hFFFF};
      vecs[3] = '{1'b0, 4'h9, 3'd2, 3'd5, 3'd7, 3'd7, 6'h15, 16'h9555};
      vecs[4] = '{1'b1, 4'hA, 3'd0, 3'd0, 3'd0, 3'd0, 6'h3F, 16'hA000};
      vecs[5] = '{1'b0, 4'h0, 3'd0, 3'd0, 3'd7, 3'd7, 6'h00, 16'h0000};
      vecs[6] = '{1'b1, 4'h3, 3'd4, 3'd1, 3'd6, 3'd2, 6'h11, 16'h3872};
      vecs[7] = '{1'b0, 4'h6, 3'd3, 3'd6, 3'd1, 3'd4, 6'h2C, 16'h67AC};

      reset = 1'b1; start = 1'b0; base_addr = '0; finish = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0;
      r_type = 1'b0; opcode = '0; rs = '0; rt = '0; rd = '0; funct = '0; immed = '0;
      tick();
      tick();
      checkOutput("reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset in_ready", 32'(in_ready), 32'd0);
      checkOutput("reset words", 32'(words), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset out_addr", 32'(out_addr), 32'd0);
      checkOutput("reset out_data", 32'(out_data), 32'd0);
      reset = 1'b0;

      finish = 1'b1;
      tick();
      finish = 1'b0;
      checkOutput("idle finish busy", 32'(busy), 32'd0);
      checkOutput("idle finish done", 32'(done), 32'd0);

      out_ready = 1'b1;
      runSession(8'h10, 0);
      runSession(8'hFE, 4);

      acceptsBefore = acceptCount;
      applyStimulus(0);
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         checkOutput("done blocks in_ready", 32'(in_ready), 32'd0);
         tick();
      end
      in_valid = 1'b0;
      checkOutput("done words held", 32'(words), 32'(DEPTH));
      checkOutput("no fifth accept", 32'(acceptCount), 32'(acceptsBefore));

      out_ready = 1'b0;
      startSession(8'h40);
      sendWord(0);
      sendWord(1);
      applyStimulus(2);
      in_valid = 1'b1;
      checkOutput("full in_ready", 32'(in_ready), 32'd0);
      tick();
      checkOutput("stall in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall out_valid", 32'(out_valid), 32'd1);
      checkOutput("stall addr", 32'(out_addr), 32'h40);
      checkOutput("stall data", 32'(out_data), 32'h029D);
      out_ready = 1'b1;
      checkOutput("full pop in_ready", 32'(in_ready), 32'd0);
      sendWord(2);
      checkOutput("backpressure words", 32'(words), 32'd3);
      tick();
      tick();
      finish = 1'b1;
      tick();
      finish = 1'b0;
      checkOutput("finish drain busy", 32'(busy), 32'd1);
      tick();
      checkOutput("finish done", 32'(done), 32'd1);
      checkOutput("finish words", 32'(words), 32'd3);

      startSession(8'h20);
      sendWord(6);
      applyStimulus(7);
      in_valid = 1'b1;
      finish   = 1'b1;
      checkOutput("finish accept ready", 32'(in_ready), 32'd1);
      tick();
      finish = 1'b0;
      applyStimulus(0);
      checkOutput("early drain in_ready", 32'(in_ready), 32'd0);
      checkOutput("early drain done", 32'(done), 32'd0);
      checkOutput("early drain addr", 32'(out_addr), 32'h21);
      checkOutput("early drain data", 32'(out_data), 32'h67AC);
      checkOutput("early drain words", 32'(words), 32'd2);
      tick();
      in_valid = 1'b0;
      checkOutput("early done", 32'(done), 32'd1);
      checkOutput("early busy", 32'(busy), 32'd0);
      checkOutput("early words", 32'(words), 32'd2);
      checkOutput("early out_valid", 32'(out_valid), 32'd0);
      finish = 1'b1;
      tick();
      finish = 1'b0;
      checkOutput("done finish done", 32'(done), 32'd1);
      checkOutput("done finish words", 32'(words), 32'd2);
      checkOutput("scoreboard empty", 32'(expQ.size()), 32'd0);
      checkOutput("total accepts", 32'(acceptCount), 32'd13);

      out_ready = 1'b0;
      startSession(8'h30);
      sendWord(0);
      sendWord(1);
      checkOutput("pre-reset in_ready", 32'(in_ready), 32'd0);
      checkOutput("pre-reset out_valid", 32'(out_valid), 32'd1);
      reset    = 1'b1;
      start    = 1'b1;
      in_valid = 1'b1;
      applyStimulus(2);
      tick();
      checkOutput("mid reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("mid reset words", 32'(words), 32'd0);
      checkOutput("mid reset busy", 32'(busy), 32'd0);
      checkOutput("mid reset done", 32'(done), 32'd0);
      checkOutput("mid reset in_ready", 32'(in_ready), 32'd0);
      expQ.delete();
      reset    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      tick();
      checkOutput("post reset busy", 32'(busy), 32'd0);
      checkOutput("post reset out_valid", 32'(out_valid), 32'd0);

      $display("%0d/%0d checks passed", passChecks, totalChecks);
      $finish;
   end

endmodule

// File: doc/instr_word_packer.md
# instr_word_packer

Instruction word packer for the 16-bit miniMIPS program loader: the encode-side counterpart of the instruction field split. It takes decoded fields (opcode, rs, rt, rd, funct, immed) one instruction at a time over a valid/ready handshake and packs each into a 16-bit instruction word. It tags each word with a sequential instruction-memory address and streams the address/word pairs through a 2-entry buffer to the instruction-memory write port. A small FSM runs the load session from start to done.

## Interface
- ADDR_W, default 8: instruction-memory address width.
- DEPTH, default 256: maximum words per session; must be ≤ 2^ADDR_W.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a session; samples base_addr.
- base_addr  in  ADDR_W  address of the first word of the session.
- finish  in  1  ends the session early (end of program).
- in_valid  in  1  field set is valid.
- in_ready  out  1  packer accepts the field set this cycle.
- r_type  in  1  1 = R-format (uses rd, funct); 0 = I-format (uses immed).
- opcode  in  4  opcode field.
- rs, rt, rd  in  3 each  register fields.
- funct  in  3  function field.
- immed  in  6  immediate field.
- out_valid  out  1  buffer head holds a word for memory.
- out_ready  in  1  memory takes the head word this cycle.
- out_addr  out  ADDR_W  write address of the head word.
- out_data  out  16  packed head word.
- words  out  ADDR_W+1  words accepted in the current session.
- busy  out  1  high in LOAD or DRAIN.
- done  out  1  high in DONE.

## Operation
- Packing:
  - R-format: {opcode, rs, rt, rd, funct}, i.e. [15:12] opcode, [11:9] rs, [8:6] rt, [5:3] rd, [2:0] funct.
  - I-format: {opcode, rs, rt, immed}, with immed in [5:0].
  - Fields unused by the selected format are ignored.
- Accept = in_valid && in_ready. On accept:
  - the packed word and address (base + words, mod 2^ADDR_W) are pushed into the buffer;
  - words increments.
- Pop = out_valid && out_ready. It removes the head entry.
- Buffer: 2-entry FIFO with occupancy 0..2. out_valid = occupancy ≠ 0. out_addr and out_data show the head entry and stay stable while out_valid && !out_ready.
- in_ready = (state == LOAD) && occupancy < 2. in_ready has no combinational path from out_ready. At occupancy 2 with a pop in the same cycle, in_ready is still low.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE: on start, latch base_addr, clear words, go to LOAD.
  - LOAD:
    - If finish, go to DRAIN. An accept in that same cycle still completes.
    - If an accept makes words == DEPTH, go to DRAIN.
    - start is ignored.
  - DRAIN: no accepts. When occupancy reaches 0 (including by a pop this cycle), go to DONE on the next edge.
  - DONE: done = 1 and words holds its final value. On start, begin a new session exactly as from IDLE.
- Address wrap: base + index wraps modulo 2^ADDR_W without error.

## Timing
- Reset values: state IDLE, buffer empty, out_valid 0, in_ready 0, words 0, busy 0, done 0. out_addr and out_data are 0.
- Reset wins over every other input in the same cycle, and aborts a session mid-operation. Buffered words are discarded.
- start → LOAD on the next edge. in_ready can be high in the first LOAD cycle.
- Latency: a word accepted at edge N appears at the buffer head with out_valid = 1 after edge N, provided the buffer was empty.
- Throughput: one word per cycle with out_ready held high.
- Simultaneous push and pop at occupancy 1 leaves occupancy at 1, and the head advances correctly.
- done rises one edge after the buffer empties in DRAIN. It falls on the edge after a start pulse, or on reset.
- A finish received in IDLE or DONE is ignored.

## Test plan
- R-format pack: start with base 0x10; send opcode 0x0, rs 1, rt 2, rd 3, funct 5, r_type 1. Required: out_addr 0x10, out_data 0x029D, one cycle after accept.
- I-format pack: opcode 0x4, rs 7, rt 0, immed 0x3F, r_type 0, with rd/funct set to non-zero junk. Required: out_data 0x4E3F and words 1; the junk fields must not affect the word.
- Backpressure: out_ready 0 and three consecutive valid field sets. Required: two accepted, then in_ready 0. Raising out_ready drains the words in order at addresses base, base+1; the third field set is then accepted at base+2.
- Session end by DEPTH: with DEPTH 4 and base 0xFE, stream 4 words. Required: addresses 0xFE, 0xFF, 0x00, 0x01; DRAIN, then done 1 with words 4; a 5th in_valid is never accepted.
- Early finish: finish asserted together with an accepted word. Required: that word is written, no further accepts, and done rises one edge after the last pop.
- Reset mid-session: assert reset with occupancy 2. Required: next cycle out_valid 0, words 0, busy 0, done 0, in_ready 0.
